// File: rtl/watch_mode_ctrl.sv
// rtl/watch_mode_ctrl.sv - button conditioning, display mode select and stopwatch sequencer
module watch_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic       sysclk,
    input  logic       i_rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_run,
    output logic       o_mode,
    output logic       o_sw_run,
    output logic       o_sw_clear,
    output logic [1:0] o_sw_state
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    localparam int B_MODE = 0;
    localparam int B_RUN  = 1;

    logic [1:0]        w_btn_raw;
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_db;
    logic [1:0]        r_db_d;
    logic [DB_W-1:0]   r_db_cnt [2];

    logic [1:0]        w_press;
    logic              w_run_release;
    logic              w_long;
    logic              w_short;

    logic              r_mode;
    logic [HOLD_W-1:0] r_hold;
    logic [TO_W-1:0]   r_to;
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_sw_run;
    logic              r_sw_clear;

    assign w_btn_raw = {i_btn_run, i_btn_mode};

    // Debounce counter only advances while the synchronized level disagrees with the accepted one.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press       = r_db & ~r_db_d;
    assign w_run_release = ~r_db[B_RUN] & r_db_d[B_RUN];

    // Run events use the pre-toggle mode, so a coincident mode press cannot gate them.
    assign w_long  = r_mode && r_db[B_RUN] && (r_hold == HOLD_LAST);
    assign w_short = r_mode && w_run_release && (r_hold < HOLD_MAX);

    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (!r_mode || !r_db[B_RUN]) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_long) begin
            w_state_next = S_IDLE;
        end else if (w_short) begin
            case (r_state)
                S_IDLE:  w_state_next = S_RUN;
                S_RUN:   w_state_next = S_PAUSE;
                S_PAUSE: w_state_next = S_RUN;
                default: w_state_next = S_IDLE;
            endcase
        end else if (r_state == 2'b11) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sw_run   <= 1'b0;
            r_sw_clear <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sw_run   <= (w_state_next == S_RUN);
            r_sw_clear <= w_long;
        end
    end

    // A mode press outranks the timeout; both leave o_mode at 0 when they coincide.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_mode <= 1'b0;
            r_to   <= '0;
        end else if (w_press[B_MODE]) begin
            r_mode <= ~r_mode;
            r_to   <= '0;
        end else if (!r_mode || (r_state != S_IDLE) || (|w_press)) begin
            r_to <= '0;
        end else if (r_to == TO_MAX) begin
            r_mode <= 1'b0;
            r_to   <= '0;
        end else begin
            r_to <= r_to + 1'b1;
        end
    end

    assign o_mode     = r_mode;
    assign o_sw_run   = r_sw_run;
    assign o_sw_clear = r_sw_clear;
    assign o_sw_state = r_state;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb/tb_watch_mode_ctrl.sv - directed table-driven bench for watch_mode_ctrl
module tb_watch_mode_ctrl;

    typedef struct {
        string      name;
        logic       bm;
        logic       br;
        int         cyc;
        logic       e_mode;
        logic       e_run;
        logic       e_clear;
        logic [1:0] e_state;
    } vec_t;

    logic       sysclk = 1'b0;
    logic       i_rst;
    logic       i_btn_mode;
    logic       i_btn_run;
    logic       o_mode;
    logic       o_sw_run;
    logic       o_sw_clear;
    logic [1:0] o_sw_state;

    int   n_vec = 0;
    int   n_err = 0;
    int   clear_cnt = 0;
    vec_t tbl[$];

    watch_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .sysclk    (sysclk),
        .i_rst     (i_rst),
        .i_btn_mode(i_btn_mode),
        .i_btn_run (i_btn_run),
        .o_mode    (o_mode),
        .o_sw_run  (o_sw_run),
        .o_sw_clear(o_sw_clear),
        .o_sw_state(o_sw_state)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (o_sw_clear === 1'b1) clear_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic bm, input logic br, input int cyc,
                       input logic em, input logic er, input logic ec, input logic [1:0] es);
        vec_t v;
        v.name = nm; v.bm = bm; v.br = br; v.cyc = cyc;
        v.e_mode = em; v.e_run = er; v.e_clear = ec; v.e_state = es;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // name, mode btn, run btn, cycles, expected mode/run/clear/state
        add("dbn_short_hi",   1, 0,  3, 0, 0, 0, 2'b00);
        add("dbn_short_lo",   0, 0, 10, 0, 0, 0, 2'b00);
        add("dbn_hold_pre",   1, 0,  6, 0, 0, 0, 2'b00);
        add("dbn_hold_edge7", 0, 0,  1, 1, 0, 0, 2'b00);
        add("mode_settle",    0, 0,  8, 1, 0, 0, 2'b00);
        add("p1_hold",        0, 1,  8, 1, 0, 0, 2'b00);
        add("p1_rel_pre",     0, 0,  6, 1, 0, 0, 2'b00);
        add("p1_start",       0, 0,  1, 1, 1, 0, 2'b01);
        add("p1_settle",      0, 0,  4, 1, 1, 0, 2'b01);
        add("p2_hold",        0, 1,  8, 1, 1, 0, 2'b01);
        add("p2_pause",       0, 0,  7, 1, 0, 0, 2'b10);
        add("p2_settle",      0, 0,  4, 1, 0, 0, 2'b10);
        add("p3_hold",        0, 1,  8, 1, 0, 0, 2'b10);
        add("p3_resume",      0, 0,  7, 1, 1, 0, 2'b01);
        add("p3_settle",      0, 0,  4, 1, 1, 0, 2'b01);
        add("long_pre",       0, 1, 25, 1, 1, 0, 2'b01);
        add("long_clear",     0, 1,  1, 1, 0, 1, 2'b00);
        add("long_after",     0, 1,  1, 1, 0, 0, 2'b00);
        add("long_hold",      0, 1, 13, 1, 0, 0, 2'b00);
        add("long_release",   0, 0, 12, 1, 0, 0, 2'b00);
        add("bg_hold",        0, 1,  8, 1, 0, 0, 2'b00);
        add("bg_start",       0, 0,  7, 1, 1, 0, 2'b01);
        add("bg_settle",      0, 0,  4, 1, 1, 0, 2'b01);
        add("bg_mode_off",    1, 0,  7, 0, 1, 0, 2'b01);
        add("bg_mode_settle", 0, 0,  8, 0, 1, 0, 2'b01);
        add("clk_long_hold",  0, 1, 40, 0, 1, 0, 2'b01);
        add("clk_long_rel",   0, 0, 10, 0, 1, 0, 2'b01);

        // Reset with both buttons held, then the held mode button debounces in
        i_rst = 1'b1; i_btn_mode = 1'b1; i_btn_run = 1'b1;
        tick(2);
        chk("rst_outputs", {o_mode, o_sw_run, o_sw_clear, o_sw_state}, 5'b00000);
        i_rst = 1'b0;
        tick(6);
        chk("rst_mode_edge6", o_mode, 1'b0);
        tick(1);
        chk("rst_mode_edge7", o_mode, 1'b1);
        i_btn_mode = 1'b0; i_btn_run = 1'b0;
        tick(20);
        chk("rst_run_release_short", {o_mode, o_sw_run, o_sw_state}, 4'b1101);
        chk("rst_no_clear", clear_cnt, 0);

        i_rst = 1'b1;
        tick(2);
        chk("rst2_outputs", {o_mode, o_sw_run, o_sw_clear, o_sw_state}, 5'b00000);
        i_rst = 1'b0;

        foreach (tbl[k]) begin
            i_btn_mode = tbl[k].bm;
            i_btn_run  = tbl[k].br;
            tick(tbl[k].cyc);
            chk(tbl[k].name, {o_mode, o_sw_run, o_sw_clear, o_sw_state},
                {tbl[k].e_mode, tbl[k].e_run, tbl[k].e_clear, tbl[k].e_state});
        end
        chk("clear_pulses_table", clear_cnt, 1);

        // Timeout from IDLE with nothing pressed
        i_rst = 1'b1; i_btn_mode = 1'b0; i_btn_run = 1'b0;
        tick(2);
        i_rst = 1'b0;
        i_btn_mode = 1'b1;
        tick(7);
        chk("to_enter", o_mode, 1'b1);
        i_btn_mode = 1'b0;
        tick(50);
        chk("to_edge50", o_mode, 1'b1);
        tick(1);
        chk("to_edge51", o_mode, 1'b0);

        // Run press 30 edges in restarts the count; its long press does not
        i_btn_mode = 1'b1;
        tick(7);
        chk("to2_enter", o_mode, 1'b1);
        i_btn_mode = 1'b0;
        tick(23);
        i_btn_run = 1'b1;
        tick(30);
        i_btn_run = 1'b0;
        tick(7);
        chk("to2_restart_held", {o_mode, o_sw_state}, 3'b100);
        chk("clear_pulses_idle_long", clear_cnt, 2);
        tick(20);
        chk("to2_edge80", o_mode, 1'b1);
        tick(1);
        chk("to2_edge81", o_mode, 1'b0);

        // No timeout while RUN
        i_btn_mode = 1'b1;
        tick(7);
        chk("to3_enter", o_mode, 1'b1);
        i_btn_mode = 1'b0;
        i_btn_run  = 1'b1;
        tick(8);
        i_btn_run = 1'b0;
        tick(7);
        chk("to3_run", {o_sw_run, o_sw_state}, 3'b101);
        tick(100);
        chk("to3_no_timeout_in_run", {o_mode, o_sw_state}, 3'b101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
